// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-FF synchronizer, 3-sample majority vote per bit,
// configurable data/parity/stop format, break detection, one-entry output buffer.
module uart_rx_os #(
  parameter int CLK_HZ       = 27_000_000,
  parameter int BIT_RATE     = 115200,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int OVERSAMPLE   = 16
) (
  input  logic                    CLK_I,
  input  logic                    RST_N_I,
  input  logic                    RX_D_I,
  input  logic                    RX_EN_I,
  input  logic                    RX_RDY_I,
  output logic                    RX_VLD_O,
  output logic [PAYLOAD_BITS-1:0] RX_D_O,
  output logic                    RX_PERR_O,
  output logic                    RX_FERR_O,
  output logic                    RX_BREAK_O,
  output logic                    RX_OVR_O,
  output logic                    RX_BUSY_O
);

  localparam int DIV_R = (CLK_HZ + (BIT_RATE * OVERSAMPLE) / 2) / (BIT_RATE * OVERSAMPLE);
  localparam int DIV   = (DIV_R < 1) ? 1 : DIV_R;
  localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW    = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] P_END   = PW'(DIV - 1);
  localparam logic [SW-1:0] S_A     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_B     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_C     = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END   = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BC_DATA = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0]    BC_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP, ST_BRK} state_t;

  state_t                  state, state_n;
  logic [1:0]              sync_q;
  logic                    rxs;
  logic [PW-1:0]           pcnt;
  logic [SW-1:0]           scnt;
  logic                    tick, samp3, bit_end, last_vote;
  logic                    s0, s1, s2, vote, vote_now;
  logic [3:0]              bcnt;
  logic [PAYLOAD_BITS-1:0] sh;
  logic                    par_q, ferr_acc;
  logic                    done, busy, perr_now, ferr_now, brk_now;
  logic                    vld_q, perr_q, ferr_q, brk_q, ovr_q;
  logic [PAYLOAD_BITS-1:0] d_q;

  always_ff @(posedge CLK_I or negedge RST_N_I)
    if (!RST_N_I) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], RX_D_I};

  assign rxs       = sync_q[1];
  assign tick      = (pcnt == P_END);
  assign samp3     = tick && (scnt == S_C);
  assign bit_end   = tick && (scnt == S_END);
  assign last_vote = samp3 && (bcnt == BC_STOP);
  assign vote      = (s0 & s1) | (s0 & s2) | (s1 & s2);
  // Vote on the third sample itself so the final stop bit can complete mid-bit.
  assign vote_now  = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign ferr_now  = ferr_acc | ~vote_now;
  assign perr_now  = (PARITY == 1) ? ~(^sh ^ par_q) :
                     (PARITY == 2) ?  (^sh ^ par_q) : 1'b0;
  assign brk_now   = ~|sh && ((PARITY == 0) ? 1'b1 : ~par_q) && ferr_now;

  always_ff @(posedge CLK_I or negedge RST_N_I)
    if (!RST_N_I) state <= ST_IDLE;
    else          state <= state_n;

  always_comb begin
    state_n = state;
    if (state != ST_IDLE && !RX_EN_I) state_n = ST_IDLE;
    else begin
      case (state)
        ST_IDLE:  if (RX_EN_I && !rxs) state_n = ST_START;
        ST_START: if (bit_end) state_n = vote ? ST_IDLE : ST_DATA;
        ST_DATA:  if (bit_end && bcnt == BC_DATA) state_n = (PARITY != 0) ? ST_PAR : ST_STOP;
        ST_PAR:   if (bit_end) state_n = ST_STOP;
        ST_STOP:  if (last_vote) state_n = brk_now ? ST_BRK : ST_IDLE;
        ST_BRK:   if (rxs) state_n = ST_IDLE;
        default:  state_n = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_STOP) && RX_EN_I && last_vote;
  end

  always_ff @(posedge CLK_I or negedge RST_N_I)
    if (!RST_N_I) begin
      pcnt <= '0; scnt <= '0; s0 <= 1'b0; s1 <= 1'b0; s2 <= 1'b0;
      bcnt <= '0; sh <= '0; par_q <= 1'b0; ferr_acc <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        pcnt <= '0;
        scnt <= '0;
      end else if (tick) begin
        pcnt <= '0;
        scnt <= (scnt == S_END) ? '0 : scnt + 1'b1;
      end else pcnt <= pcnt + 1'b1;
      if (tick && scnt == S_A) s0 <= rxs;
      if (tick && scnt == S_B) s1 <= rxs;
      if (tick && scnt == S_C) s2 <= rxs;
      // bcnt counts bits within the current state; it restarts on every transition.
      if (state != state_n)  bcnt <= '0;
      else if (bit_end)      bcnt <= bcnt + 1'b1;
      if (state == ST_DATA && bit_end) sh <= {vote, sh[PAYLOAD_BITS-1:1]};
      if (state == ST_PAR && bit_end)  par_q <= vote;
      if (state != ST_STOP)  ferr_acc <= 1'b0;
      else if (bit_end)      ferr_acc <= ferr_acc | ~vote;
    end

  always_ff @(posedge CLK_I or negedge RST_N_I)
    if (!RST_N_I) begin
      vld_q <= 1'b0; d_q <= '0; perr_q <= 1'b0; ferr_q <= 1'b0; brk_q <= 1'b0; ovr_q <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done) begin
        if (!vld_q || RX_RDY_I) begin
          vld_q  <= 1'b1;
          d_q    <= sh;
          perr_q <= perr_now;
          ferr_q <= ferr_now;
          brk_q  <= brk_now;
        end else ovr_q <= 1'b1;
      end else if (vld_q && RX_RDY_I) vld_q <= 1'b0;
    end

  assign RX_VLD_O   = vld_q;
  assign RX_D_O     = d_q;
  assign RX_PERR_O  = perr_q;
  assign RX_FERR_O  = ferr_q;
  assign RX_BREAK_O = brk_q;
  assign RX_OVR_O   = ovr_q;
  assign RX_BUSY_O  = busy;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: three receivers (8N1, 8E1, 7O2) at 16 clocks per bit,
// each with its own line, checked against a frame-level reference model.
module tb_uart_rx_os;
  localparam int CLK_HZ = 16_000_000;
  localparam int BR     = 1_000_000;
  localparam int OS     = 16;
  localparam int BT     = 16;
  localparam int GAP    = 40;

  logic       clk = 1'b0;
  logic       rst_n, en, rdy;
  logic [2:0] rx, vld, perr, ferr, brk, ovr, busy;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  int         checks = 0, errors = 0;
  int         cyc = 0, t_start = 0, t_rise = 0, ovr_cnt = 0;
  logic       vld0_d = 1'b0;
  int         capq[$], expq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_os #(.CLK_HZ(CLK_HZ), .BIT_RATE(BR), .PAYLOAD_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS)) u_n1 (
    .CLK_I(clk), .RST_N_I(rst_n), .RX_D_I(rx[0]), .RX_EN_I(en), .RX_RDY_I(rdy),
    .RX_VLD_O(vld[0]), .RX_D_O(d0), .RX_PERR_O(perr[0]), .RX_FERR_O(ferr[0]),
    .RX_BREAK_O(brk[0]), .RX_OVR_O(ovr[0]), .RX_BUSY_O(busy[0]));
  uart_rx_os #(.CLK_HZ(CLK_HZ), .BIT_RATE(BR), .PAYLOAD_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(OS)) u_e1 (
    .CLK_I(clk), .RST_N_I(rst_n), .RX_D_I(rx[1]), .RX_EN_I(en), .RX_RDY_I(rdy),
    .RX_VLD_O(vld[1]), .RX_D_O(d1), .RX_PERR_O(perr[1]), .RX_FERR_O(ferr[1]),
    .RX_BREAK_O(brk[1]), .RX_OVR_O(ovr[1]), .RX_BUSY_O(busy[1]));
  uart_rx_os #(.CLK_HZ(CLK_HZ), .BIT_RATE(BR), .PAYLOAD_BITS(7), .PARITY(1), .STOP_BITS(2), .OVERSAMPLE(OS)) u_o2 (
    .CLK_I(clk), .RST_N_I(rst_n), .RX_D_I(rx[2]), .RX_EN_I(en), .RX_RDY_I(rdy),
    .RX_VLD_O(vld[2]), .RX_D_O(d2), .RX_PERR_O(perr[2]), .RX_FERR_O(ferr[2]),
    .RX_BREAK_O(brk[2]), .RX_OVR_O(ovr[2]), .RX_BUSY_O(busy[2]));

  function automatic int pk(int ch, int b, int f, int p, int d);
    return (ch << 16) | (b << 11) | (f << 10) | (p << 9) | d;
  endfunction

  function automatic int nb(int ch); return (ch == 2) ? 7 : 8; endfunction
  function automatic int pm(int ch); return (ch == 1) ? 2 : (ch == 2) ? 1 : 0; endfunction
  function automatic int ns(int ch); return (ch == 2) ? 2 : 1; endfunction

  // Parity bit placed on the wire: correct for the format, optionally inverted.
  function automatic int pbit_of(int ch, int data, int pflip);
    int ones;
    ones = $countones(data & ((1 << nb(ch)) - 1));
    return ((pm(ch) == 2) ? (ones & 1) : (~ones & 1)) ^ (pflip & 1);
  endfunction

  // Reference model: the word a receiver must report for a given wire frame.
  function automatic int expect_word(int ch, int data, int pflip, int stop_bad);
    int d, p, total, pe, fe, bk;
    d     = data & ((1 << nb(ch)) - 1);
    p     = (pm(ch) != 0) ? pbit_of(ch, data, pflip) : 0;
    total = $countones(d) + p;
    pe    = (pm(ch) == 1) ? int'(total % 2 == 0) : (pm(ch) == 2) ? int'(total % 2 == 1) : 0;
    fe    = int'(stop_bad != 0);
    bk    = int'(d == 0 && p == 0 && fe == 1);
    return pk(ch, bk, fe, pe, d);
  endfunction

  always @(negedge clk) begin
    if (vld[0] && rdy) capq.push_back(pk(0, brk[0], ferr[0], perr[0], d0));
    if (vld[1] && rdy) capq.push_back(pk(1, brk[1], ferr[1], perr[1], d1));
    if (vld[2] && rdy) capq.push_back(pk(2, brk[2], ferr[2], perr[2], d2));
    if (vld[0] && !vld0_d) t_rise <= cyc;
    vld0_d  <= vld[0];
    ovr_cnt <= ovr_cnt + int'(ovr[0]);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_count"}, capq.size(), expq.size());
    for (int i = 0; i < capq.size() && i < expq.size(); i++) chk(tag, capq[i], expq[i]);
    capq.delete();
    expq.delete();
  endtask

  // Drive one frame; gbit selects a wire bit that gets a 1-clock inversion at its centre.
  task automatic send(input int ch, input int data, input int pflip, input int stop_bad,
                      input int gbit, input bit push);
    bit q[$];
    int pb;
    q.push_back(1'b0);
    for (int i = 0; i < nb(ch); i++) q.push_back(data[i]);
    pb = pbit_of(ch, data, pflip);
    if (pm(ch) != 0) q.push_back(pb[0]);
    for (int s = 0; s < ns(ch); s++) q.push_back(!stop_bad[s]);
    t_start = cyc;
    foreach (q[k])
      for (int c = 0; c < BT; c++) begin
        rx[ch] = (k == gbit && c == 8) ? ~q[k] : q[k];
        @(negedge clk);
      end
    rx[ch] = 1'b1;
    repeat (GAP) @(negedge clk);
    if (push) expq.push_back(expect_word(ch, data, pflip, stop_bad));
  endtask

  initial begin
    int dat, pf, sb, o0;
    rst_n = 1'b0; en = 1'b1; rdy = 1'b1; rx = 3'b111;
    repeat (3) @(negedge clk);
    chk("rst_out_n1", int'({vld[0], perr[0], ferr[0], brk[0], ovr[0], busy[0], d0}), 0);
    chk("rst_out_e1", int'({vld[1], perr[1], ferr[1], brk[1], ovr[1], busy[1], d1}), 0);
    chk("rst_out_o2", int'({vld[2], perr[2], ferr[2], brk[2], ovr[2], busy[2], d2}), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    send(0, 8'hA5, 0, 0, -1, 1);
    chk("latency_in_window", int'((t_rise - t_start) >= 140 && (t_rise - t_start) <= 180), 1);
    check_words("n1_a5");

    for (int i = 0; i < 5; i++) begin
      dat = int'($urandom_range(0, 255));
      sb  = int'($urandom_range(0, 3) == 0);
      send(0, dat, 0, sb, -1, 1);
    end
    check_words("n1_rand");

    send(1, 8'h03, 0, 0, -1, 1);
    send(1, 8'h03, 1, 0, -1, 1);
    for (int i = 0; i < 3; i++) begin
      dat = int'($urandom_range(0, 255));
      pf  = int'($urandom_range(0, 1));
      send(1, dat, pf, 0, -1, 1);
    end
    check_words("e1");

    send(2, 7'h7F, 0, 0, -1, 1);
    send(2, 7'h7F, 1, 0, -1, 1);
    for (int i = 0; i < 4; i++) begin
      dat = int'($urandom_range(0, 127));
      pf  = int'($urandom_range(0, 1));
      sb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      send(2, dat, pf, sb, -1, 1);
    end
    check_words("o2");

    rx[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_busy", int'(busy[0]), 0);
    check_words("glitch_start");

    send(0, 8'h55, 0, 0, 4, 1);
    check_words("glitch_data");

    rx[0] = 1'b0;
    repeat (400) @(negedge clk);
    chk("brk_busy_mid", int'(busy[0]), 1);
    repeat (80) @(negedge clk);
    chk("brk_busy_end", int'(busy[0]), 1);
    rx[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("brk_busy_release", int'(busy[0]), 0);
    expq.push_back(expect_word(0, 0, 0, 1));
    repeat (20) @(negedge clk);
    check_words("brk");
    send(0, 8'h41, 0, 0, -1, 1);
    check_words("after_brk");

    rdy = 1'b0;
    o0 = ovr_cnt;
    send(0, 8'h11, 0, 0, -1, 1);
    send(0, 8'h22, 0, 0, -1, 0);
    chk("ovr_hold_d", int'(d0), 8'h11);
    chk("ovr_hold_vld", int'(vld[0]), 1);
    chk("ovr_pulses", ovr_cnt - o0, 1);
    rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("ovr_vld_fall", int'(vld[0]), 0);
    send(0, 8'h33, 0, 0, -1, 1);
    check_words("ovr");

    rdy = 1'b0;
    send(0, 8'h5A, 0, 0, -1, 0);
    chk("pre_rst_vld", int'(vld[0]), 1);
    rx[0] = 1'b0; repeat (BT) @(negedge clk);
    rx[0] = 1'b1; repeat (2 * BT) @(negedge clk);
    rx[0] = 1'b0; repeat (BT / 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_out", int'({vld[0], perr[0], ferr[0], brk[0], ovr[0], busy[0], d0}), 0);
    rx[0] = 1'b1;
    rdy   = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_words("rst_quiet");
    send(0, 8'h3C, 0, 0, -1, 1);
    check_words("after_rst");

    fork
      send(0, 8'h96, 0, 0, -1, 0);
      begin
        repeat (60) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("en_drop_busy", int'(busy[0]), 0);
      end
    join
    en = 1'b1;
    repeat (20) @(negedge clk);
    check_words("en_drop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
